// File: rtl/shift_unit_iter.sv
// Iterative LSL/LSR/ASR/ROR unit, STEP bit positions per clock.
// Start/busy/done handshake with ARMv6-M style N/Z/C flag results.
module shift_unit_iter #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             S,
    input  logic [1:0]       stype,
    input  logic [WIDTH-1:0] Rm,
    input  logic [AMT_W-1:0] shift_amt,
    input  logic             carry_in,
    input  logic             zero_in,
    input  logic             neg_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Rd,
    output logic             carry_out,
    output logic             zero_out,
    output logic             neg_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);

    localparam logic [CW-1:0] STEP_C  = CW'(STEP);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

    localparam logic [1:0] T_LSL = 2'b00;
    localparam logic [1:0] T_LSR = 2'b01;
    localparam logic [1:0] T_ASR = 2'b10;
    localparam logic [1:0] T_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] val_q;
    logic [CW-1:0]    rem_q;
    logic [1:0]       type_q;
    logic             s_q;
    logic             cin_q;
    logic             zin_q;
    logic             nin_q;
    logic             sign_q;
    logic             over_q;
    logic             cout_q;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] rd_q;
    logic             carry_q;
    logic             zero_q;
    logic             neg_q;

    logic [31:0]      amt_ext;
    logic             amt_zero;
    logic             amt_over;
    logic [CW-1:0]    e_d;
    logic             c0_d;

    // Effective count at accept: saturate for plain shifts, wrap for ROR.
    always_comb begin
        amt_ext  = 32'(shift_amt);
        amt_zero = (amt_ext == 32'd0);
        amt_over = (amt_ext > 32'(WIDTH));
        if (stype == T_ROR) begin
            e_d = CW'(amt_ext % 32'(WIDTH));
        end else if (amt_over) begin
            e_d = WIDTH_C;
        end else begin
            e_d = CW'(amt_ext);
        end
        c0_d = amt_zero ? carry_in : Rm[WIDTH-1];
    end

    logic [CW-1:0]    k_d;
    logic [CW-1:0]    rem_d;
    logic [WIDTH-1:0] lo_d;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] fill_d;
    logic [WIDTH-1:0] step_d;
    logic             cout_d;
    logic             cfin_d;

    always_comb begin
        k_d    = (rem_q > STEP_C) ? STEP_C : rem_q;
        rem_d  = rem_q - k_d;
        lo_d   = val_q >> k_d;
        hi_d   = val_q << (WIDTH_C - k_d);
        fill_d = ~({WIDTH{1'b1}} >> k_d) & {WIDTH{sign_q}};
        step_d = val_q;
        cout_d = cout_q;
        case (type_q)
            T_LSL: begin
                step_d = hi_d;
                step_d = val_q << k_d;
                cout_d = val_q[IW'(WIDTH_C - k_d)];
            end
            T_LSR: begin
                step_d = lo_d;
                cout_d = val_q[IW'(k_d - CW'(1))];
            end
            T_ASR: begin
                step_d = lo_d | fill_d;
                cout_d = val_q[IW'(k_d - CW'(1))];
            end
            default: begin
                step_d = lo_d | hi_d;
            end
        endcase
    end

    // Over-range LSL/LSR shifts the last set bit out past the carry.
    always_comb begin
        if (type_q == T_ROR) begin
            cfin_d = step_d[WIDTH-1];
        end else if (over_q && (type_q != T_ASR)) begin
            cfin_d = 1'b0;
        end else begin
            cfin_d = cout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            val_q   <= '0;
            rem_q   <= '0;
            type_q  <= '0;
            s_q     <= 1'b0;
            cin_q   <= 1'b0;
            zin_q   <= 1'b0;
            nin_q   <= 1'b0;
            sign_q  <= 1'b0;
            over_q  <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        val_q  <= Rm;
                        rem_q  <= e_d;
                        type_q <= stype;
                        s_q    <= S;
                        cin_q  <= carry_in;
                        zin_q  <= zero_in;
                        nin_q  <= neg_in;
                        sign_q <= Rm[WIDTH-1];
                        over_q <= amt_over;
                        cout_q <= carry_in;
                        busy_q <= 1'b1;
                        if (e_d == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            rd_q    <= Rm;
                            carry_q <= S ? c0_d : carry_in;
                            zero_q  <= S ? (Rm == '0) : zero_in;
                            neg_q   <= S ? Rm[WIDTH-1] : neg_in;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    val_q  <= step_d;
                    rem_q  <= rem_d;
                    cout_q <= cout_d;
                    if (rem_d == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        rd_q    <= step_d;
                        carry_q <= s_q ? cfin_d : cin_q;
                        zero_q  <= s_q ? (step_d == '0) : zin_q;
                        neg_q   <= s_q ? step_d[WIDTH-1] : nin_q;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign Rd        = rd_q;
    assign carry_out = carry_q;
    assign zero_out  = zero_q;
    assign neg_out   = neg_q;

endmodule

// File: tb/tb_shift_unit_iter.sv
// Bench for shift_unit_iter: three instances (STEP 1/4/32) share stimulus.
// Directed table, golden-model random ops and control corner cases.
module tb_shift_unit_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        S_i;
    logic        cin;
    logic        zin;
    logic        nin;
    logic [1:0]  stype;
    logic [31:0] rm;
    logic [7:0]  amt;

    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  c_v;
    logic [2:0]  z_v;
    logic [2:0]  n_v;
    logic [31:0] rd_v [3];

    int n_tests = 0;
    int n_fail  = 0;
    int stp [3] = '{1, 4, 32};

    shift_unit_iter #(.WIDTH(32), .AMT_W(8), .STEP(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .S(S_i), .stype(stype),
        .Rm(rm), .shift_amt(amt), .carry_in(cin), .zero_in(zin),
        .neg_in(nin), .busy(busy_v[0]), .done(done_v[0]), .Rd(rd_v[0]),
        .carry_out(c_v[0]), .zero_out(z_v[0]), .neg_out(n_v[0])
    );

    shift_unit_iter #(.WIDTH(32), .AMT_W(8), .STEP(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .S(S_i), .stype(stype),
        .Rm(rm), .shift_amt(amt), .carry_in(cin), .zero_in(zin),
        .neg_in(nin), .busy(busy_v[1]), .done(done_v[1]), .Rd(rd_v[1]),
        .carry_out(c_v[1]), .zero_out(z_v[1]), .neg_out(n_v[1])
    );

    shift_unit_iter #(.WIDTH(32), .AMT_W(8), .STEP(32)) dut32 (
        .clk(clk), .rst(rst), .start(start), .S(S_i), .stype(stype),
        .Rm(rm), .shift_amt(amt), .carry_in(cin), .zero_in(zin),
        .neg_in(nin), .busy(busy_v[2]), .done(done_v[2]), .Rd(rd_v[2]),
        .carry_out(c_v[2]), .zero_out(z_v[2]), .neg_out(n_v[2])
    );

    typedef struct {
        logic [1:0]  t;
        logic [31:0] rm;
        int          n;
        logic [3:0]  f;
        logic [31:0] rd;
        logic [2:0]  czn;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input logic [1:0] t, input int n,
                                  input int s);
        int e;
        e = (t == 2'b11) ? (n % 32) : ((n > 32) ? 32 : n);
        return (e + s - 1) / s + 1;
    endfunction

    function automatic logic [34:0] model(input logic [1:0] t,
                                          input logic [31:0] a,
                                          input int n,
                                          input logic [3:0] f);
        logic [31:0] r;
        logic        c;
        int          m;
        r = a;
        c = f[2];
        if (n != 0) begin
            case (t)
                2'b00: begin
                    if (n <= 32) begin
                        r = a << n;
                        c = a[5'(32 - n)];
                    end else begin
                        r = '0;
                        c = 1'b0;
                    end
                end
                2'b01: begin
                    if (n <= 32) begin
                        r = a >> n;
                        c = a[5'(n - 1)];
                    end else begin
                        r = '0;
                        c = 1'b0;
                    end
                end
                2'b10: begin
                    if (n >= 32) begin
                        r = {32{a[31]}};
                        c = a[31];
                    end else begin
                        r = 32'($signed(a) >>> n);
                        c = a[5'(n - 1)];
                    end
                end
                default: begin
                    m = n % 32;
                    if (m != 0) r = (a >> m) | (a << (32 - m));
                    c = r[31];
                end
            endcase
        end
        if (f[3]) return {r, c, (r == 32'd0), r[31]};
        return {r, f[2], f[1], f[0]};
    endfunction

    task automatic run_op(input string tag, input logic [1:0] t,
                          input logic [31:0] a, input int n,
                          input logic [3:0] f, input logic [34:0] exp,
                          input int lat1);
        int          dc [3];
        logic [34:0] got [3];
        logic        busy_ok;
        logic        all_done;
        int          expl;
        dc = '{-1, -1, -1};
        got = '{35'd0, 35'd0, 35'd0};
        @(negedge clk);
        stype = t;
        rm = a;
        amt = 8'(n);
        {S_i, cin, zin, nin} = f;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rm = $urandom;
        amt = 8'($urandom);
        stype = 2'($urandom);
        {S_i, cin, zin, nin} = 4'($urandom);
        busy_ok = 1'b1;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            all_done = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (dc[i] < 0) begin
                    if (!busy_v[i]) busy_ok = 1'b0;
                    if (done_v[i]) begin
                        dc[i] = cyc;
                        got[i] = {rd_v[i], c_v[i], z_v[i], n_v[i]};
                    end
                end
                if (dc[i] < 0) all_done = 1'b0;
            end
            if (all_done) break;
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 3; i++) begin
            expl = (i == 0) ? lat1 : lat_of(t, n, stp[i]);
            check($sformatf("%s/step%0d done_cycle", tag, stp[i]),
                  64'(dc[i]), 64'(expl));
            check($sformatf("%s/step%0d rd_czn", tag, stp[i]),
                  64'(got[i]), 64'(exp));
        end
        check($sformatf("%s busy_until_done", tag), 64'(busy_ok), 64'd1);
        @(posedge clk);
        #1;
        check($sformatf("%s idle_after", tag), 64'({busy_v, done_v}), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    vec_t        tv [17];
    int          dc0;
    int          extra;
    logic [34:0] got0;
    logic [1:0]  rt;
    logic [31:0] ra;
    int          rn;
    logic [3:0]  rf;
    int          edge_n [6] = '{0, 1, 31, 32, 33, 64};

    initial begin
        tv[0]  = '{2'd0, 32'h8000_0001,   1, 4'b1000, 32'h0000_0002, 3'b100,  2};
        tv[1]  = '{2'd1, 32'h0000_0001,   1, 4'b1000, 32'h0000_0000, 3'b110,  2};
        tv[2]  = '{2'd1, 32'hFFFF_FFFF,  32, 4'b1000, 32'h0000_0000, 3'b110, 33};
        tv[3]  = '{2'd1, 32'hFFFF_FFFF,  33, 4'b1100, 32'h0000_0000, 3'b010, 33};
        tv[4]  = '{2'd1, 32'hFFFF_FFFF, 200, 4'b1100, 32'h0000_0000, 3'b010, 33};
        tv[5]  = '{2'd2, 32'h8000_0000,  40, 4'b1000, 32'hFFFF_FFFF, 3'b101, 33};
        tv[6]  = '{2'd3, 32'h0000_0001,   1, 4'b1000, 32'h8000_0000, 3'b101,  2};
        tv[7]  = '{2'd3, 32'h8000_0001,  32, 4'b1000, 32'h8000_0001, 3'b101,  1};
        tv[8]  = '{2'd0, 32'h0000_0000,   0, 4'b1100, 32'h0000_0000, 3'b110,  1};
        tv[9]  = '{2'd0, 32'h0000_00F1,   4, 4'b0011, 32'h0000_0F10, 3'b011,  5};
        tv[10] = '{2'd0, 32'h0000_0003,  10, 4'b1000, 32'h0000_0C00, 3'b000, 11};
        tv[11] = '{2'd2, 32'h4000_0000,  31, 4'b1000, 32'h0000_0000, 3'b110, 32};
        tv[12] = '{2'd0, 32'h0000_0001,  32, 4'b1000, 32'h0000_0000, 3'b110, 33};
        tv[13] = '{2'd2, 32'h8000_0010,   4, 4'b1000, 32'hF800_0001, 3'b001,  5};
        tv[14] = '{2'd3, 32'h0000_00F0,  36, 4'b1100, 32'h0000_000F, 3'b000,  5};
        tv[15] = '{2'd1, 32'h8000_0000,  31, 4'b1100, 32'h0000_0001, 3'b000, 32};
        tv[16] = '{2'd2, 32'h8000_0000,   0, 4'b1000, 32'h8000_0000, 3'b001,  1};

        rst = 1'b1;
        start = 1'b0;
        S_i = 1'b0;
        cin = 1'b0;
        zin = 1'b0;
        nin = 1'b0;
        stype = 2'd0;
        rm = '0;
        amt = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ctl", 64'({busy_v, done_v, c_v, z_v, n_v}), 64'd0);
        check("reset rd", 64'({rd_v[0], rd_v[1]}), 64'd0);
        check("reset rd32", 64'(rd_v[2]), 64'd0);

        // rst and start together: rst wins
        start = 1'b1;
        rm = 32'h1234_5678;
        amt = 8'd3;
        S_i = 1'b1;
        @(posedge clk);
        #1;
        check("rst_with_start", 64'({busy_v, done_v}), 64'd0);
        rst = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            run_op($sformatf("vec%0d", i), tv[i].t, tv[i].rm, tv[i].n,
                   tv[i].f, {tv[i].rd, tv[i].czn}, tv[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            rt = 2'($urandom_range(0, 3));
            ra = $urandom;
            rn = (i % 4 == 0) ? edge_n[(i / 4) % 6] : $urandom_range(0, 255);
            rf = 4'($urandom);
            run_op($sformatf("rnd%0d", i), rt, ra, rn, rf,
                   model(rt, ra, rn, rf), lat_of(rt, rn, 1));
        end

        // start pulsed during SHIFT must be ignored
        @(negedge clk);
        stype = 2'd0;
        rm = 32'h0000_0001;
        amt = 8'd8;
        {S_i, cin, zin, nin} = 4'b1100;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dc0 = -1;
        extra = 0;
        got0 = '0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (cyc == 3) begin
                start = 1'b1;
                rm = 32'h0000_FFFF;
                stype = 2'b11;
                amt = 8'd4;
            end
            if (cyc == 4) start = 1'b0;
            if (done_v[0]) begin
                if (dc0 < 0) begin
                    dc0 = cyc;
                    got0 = {rd_v[0], c_v[0], z_v[0], n_v[0]};
                end else begin
                    extra++;
                end
            end
            @(posedge clk);
            #1;
        end
        check("busy_start done_cycle", 64'(dc0), 64'd9);
        check("busy_start rd_czn", 64'(got0), {29'd0, 32'h0000_0100, 3'b000});
        check("busy_start no_second_done", 64'(extra), 64'd0);
        repeat (40) @(posedge clk);
        #1;

        // reset in the middle of a long shift
        @(negedge clk);
        stype = 2'b01;
        rm = 32'hFFFF_FFFF;
        amt = 8'd200;
        {S_i, cin, zin, nin} = 4'b1111;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("mid_shift busy", 64'(busy_v[0]), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid ctl", 64'({busy_v, done_v, c_v, z_v, n_v}), 64'd0);
        check("rst_mid rd", 64'({rd_v[0], rd_v[1]}), 64'd0);
        check("rst_mid rd32", 64'(rd_v[2]), 64'd0);
        extra = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (done_v != 3'b000) extra++;
            @(posedge clk);
            #1;
        end
        check("rst_mid no_done", 64'(extra), 64'd0);
        run_op("after_rst", 2'b11, 32'h1234_5678, 8, 4'b1000,
               {32'h7812_3456, 3'b000}, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
